gf2m_ds_mul: RTL and testbench

GF2M_DS_MUL -- requirements
Module: gf2m_ds_mul

---
 rtl/gf2m_pkg.sv | 13 +
 rtl/gf2m_ds_mul_if.sv | 16 +
 rtl/gf2m_ds_step.sv | 32 +++
 rtl/gf2m_ds_mul.sv | 116 +++++++++++
 tb/tb_gf2m_ds_mul.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gf2m_pkg.sv
// Shared constants and types for the digit-serial GF(2^m) multiplier.
// SECT163 field: f(x) = x^163 + x^7 + x^6 + x^3 + 1.
package gf2m_pkg;

  localparam int SECT163_M = 163;
  localparam logic [SECT163_M-1:0] SECT163_POLY = 163'hC9;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/gf2m_ds_mul_if.sv
// Request/response bundle for gf2m_ds_mul: operands and start/clr in,
// busy/done and the reduced product out.
interface gf2m_ds_mul_if #(
  parameter int M = gf2m_pkg::SECT163_M
);
  logic         clr;
  logic         start;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic         busy;
  logic         done;
  logic [M-1:0] z;

  modport master (output clr, start, a, b, input busy, done, z);
  modport slave  (input clr, start, a, b, output busy, done, z);
endinterface

// File: rtl/gf2m_ds_step.sv
// One digit iteration: c_next = (c * x^D mod f) xor (a * digit mod f).
// Purely combinational; the sum has degree <= M+D-1 and is fully reduced.
module gf2m_ds_step
  import gf2m_pkg::*;
#(
  parameter int           M    = SECT163_M,
  parameter int           D    = 8,
  parameter logic [M-1:0] POLY = M'(SECT163_POLY)
) (
  input  logic [M-1:0] c,
  input  logic [M-1:0] a,
  input  logic [D-1:0] digit,
  output logic [M-1:0] c_next
);

  localparam int W = M + D;

  logic [W-1:0] t;

  always_comb begin
    t = {c, {D{1'b0}}};
    for (int j = 0; j < D; j++) begin
      if (digit[j]) t = t ^ (W'(a) << j);
    end
    // Fold the top D coefficients down, highest first, so each fold only touches lower bits.
    for (int i = W - 1; i >= M; i--) begin
      if (t[i]) t = t ^ (W'({1'b1, POLY}) << (i - M));
    end
    c_next = t[M-1:0];
  end

endmodule

// File: rtl/gf2m_ds_mul.sv
// Digit-serial GF(2^M) multiplier, MSB-first digits of b, D bits per cycle.
// Latency ceil(M/D)+1 edges from start to done; start is ignored while busy.
module gf2m_ds_mul
  import gf2m_pkg::*;
#(
  parameter int           M    = SECT163_M,
  parameter int           D    = 8,
  parameter logic [M-1:0] POLY = M'(SECT163_POLY)
) (
  input  logic clk,
  input  logic rst,
  gf2m_ds_mul_if.slave bus
);

  localparam int N  = (D < 1) ? 1 : (M + D - 1) / D;
  localparam int NB = N * D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (D < 1 || D > M) begin : g_bad_digit
    $fatal(1, "gf2m_ds_mul: D must lie in 1..M");
  end
  if (POLY[0] == 1'b0) begin : g_bad_poly
    $fatal(1, "gf2m_ds_mul: POLY must have a constant term");
  end

  state_t          state, state_nxt;
  logic            load, step_en, finish;
  logic [M-1:0]    a_q, c_q, z_q, c_next;
  logic [NB-1:0]   b_q;
  logic [CW-1:0]   cnt;
  logic            fin;
  logic            done_q;

  gf2m_ds_step #(.M(M), .D(D), .POLY(POLY)) u_step (
    .c      (c_q),
    .a      (a_q),
    .digit  (b_q[NB-1 -: D]),
    .c_next (c_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step_en   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // One extra RUN cycle after the last digit moves the result into z.
        if (fin) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else begin
          step_en = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.clr) begin
      state_nxt = IDLE;
      load      = 1'b0;
      step_en   = 1'b0;
      finish    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      z_q    <= '0;
      cnt    <= '0;
      fin    <= 1'b0;
      done_q <= 1'b0;
    end else if (bus.clr) begin
      c_q    <= '0;
      cnt    <= '0;
      fin    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        a_q <= bus.a;
        b_q <= NB'(bus.b);
        c_q <= '0;
        cnt <= CW'(N - 1);
        fin <= 1'b0;
      end else if (step_en) begin
        c_q <= c_next;
        b_q <= b_q << D;
        cnt <= cnt - CW'(1);
        if (cnt == '0) fin <= 1'b1;
      end else if (finish) begin
        z_q    <= c_q;
        done_q <= 1'b1;
        fin    <= 1'b0;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.z    = z_q;

endmodule

// File: tb/tb_gf2m_ds_mul.sv
// Five multiplier instances (D = 1, 7, 8, 64, 163) share one stimulus stream
// and are compared against a bit-serial GF(2^163) reference.
module tb_gf2m_ds_mul;
  import gf2m_pkg::*;

  localparam int M  = 163;
  localparam int NK = 5;
  localparam int K8 = 2;
  localparam int DV [NK] = '{1, 7, 8, 64, 163};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic start = 1'b0;
  logic [M-1:0] a_in = '0;
  logic [M-1:0] b_in = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gf2m_ds_mul_if #(.M(M)) if_d1 ();
  gf2m_ds_mul_if #(.M(M)) if_d7 ();
  gf2m_ds_mul_if #(.M(M)) if_d8 ();
  gf2m_ds_mul_if #(.M(M)) if_d64 ();
  gf2m_ds_mul_if #(.M(M)) if_d163 ();

  gf2m_ds_mul #(.M(M), .D(1),   .POLY(SECT163_POLY)) u_d1   (.clk(clk), .rst(rst), .bus(if_d1));
  gf2m_ds_mul #(.M(M), .D(7),   .POLY(SECT163_POLY)) u_d7   (.clk(clk), .rst(rst), .bus(if_d7));
  gf2m_ds_mul #(.M(M), .D(8),   .POLY(SECT163_POLY)) u_d8   (.clk(clk), .rst(rst), .bus(if_d8));
  gf2m_ds_mul #(.M(M), .D(64),  .POLY(SECT163_POLY)) u_d64  (.clk(clk), .rst(rst), .bus(if_d64));
  gf2m_ds_mul #(.M(M), .D(163), .POLY(SECT163_POLY)) u_d163 (.clk(clk), .rst(rst), .bus(if_d163));

  assign {if_d1.clr, if_d7.clr, if_d8.clr, if_d64.clr, if_d163.clr} = {5{clr}};
  assign {if_d1.start, if_d7.start, if_d8.start, if_d64.start, if_d163.start} = {5{start}};
  assign if_d1.a = a_in;   assign if_d1.b = b_in;
  assign if_d7.a = a_in;   assign if_d7.b = b_in;
  assign if_d8.a = a_in;   assign if_d8.b = b_in;
  assign if_d64.a = a_in;  assign if_d64.b = b_in;
  assign if_d163.a = a_in; assign if_d163.b = b_in;

  logic [NK-1:0] busy_v, done_v;
  logic [M-1:0]  z_v [NK];
  assign busy_v = {if_d163.busy, if_d64.busy, if_d8.busy, if_d7.busy, if_d1.busy};
  assign done_v = {if_d163.done, if_d64.done, if_d8.done, if_d7.done, if_d1.done};
  assign z_v[0] = if_d1.z;
  assign z_v[1] = if_d7.z;
  assign z_v[2] = if_d8.z;
  assign z_v[3] = if_d64.z;
  assign z_v[4] = if_d163.z;

  // Reference: LSB-first shift-and-add, multiplying by x and reducing one bit at a time.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [M-1:0] acc, t;
    acc = '0;
    t   = x;
    for (int i = 0; i < M; i++) begin
      if (y[i]) acc = acc ^ t;
      t = t[M-1] ? ((t << 1) ^ SECT163_POLY) : (t << 1);
    end
    return acc;
  endfunction

  function automatic logic [M-1:0] rand_m();
    logic [191:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[M-1:0];
  endfunction

  function automatic int lat_of(input int k);
    return (M + DV[k] - 1) / DV[k] + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [M-1:0] x, input logic [M-1:0] y);
    a_in  = x;
    b_in  = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget, output int lat);
    lat = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (done_v[k]) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_all_idle();
    int n;
    n = 0;
    while ((busy_v !== '0) && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (busy_v !== '0) begin
      errors++;
      $display("FAIL idle_timeout busy=%b required=%b", busy_v, 5'b0);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy_v !== '0 || done_v !== '0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b required=0", busy_v, done_v);
    end
    for (int k = 0; k < NK; k++) begin
      checks++;
      if (z_v[k] !== '0) begin
        errors++;
        $display("FAIL reset_z D=%0d z=%h required=0", DV[k], z_v[k]);
      end
    end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_one_by_one();
    int lat;
    logic [M-1:0] one;
    one = '0;
    one[0] = 1'b1;
    start_op(one, one);
    checks++;
    if (busy_v[K8] !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start busy=%b required=1", busy_v[K8]);
    end
    wait_done(K8, 40, lat);
    checks++;
    if (lat != 22) begin
      errors++;
      $display("FAIL latency_1x1 got=%0d required=22", lat);
    end
    checks++;
    if (z_v[K8] !== one) begin
      errors++;
      $display("FAIL z_1x1 got=%h required=%h", z_v[K8], one);
    end
    wait_all_idle();
  endtask

  task automatic test_wraparound();
    int lat;
    logic [M-1:0] x, y, exp_z;
    x = '0; x[M-1] = 1'b1;
    y = '0; y[1] = 1'b1;
    exp_z = 163'hC9;
    start_op(x, y);
    wait_done(K8, 40, lat);
    checks++;
    if (lat != 22 || z_v[K8] !== exp_z) begin
      errors++;
      $display("FAIL x163_reduce lat=%0d z=%h required lat=22 z=%h", lat, z_v[K8], exp_z);
    end
    wait_all_idle();
  endtask

  task automatic test_start_while_busy();
    logic [M-1:0] a1, b1, a2, b2, z_first;
    int ndone, first_edge;
    a1 = rand_m(); b1 = rand_m();
    a2 = rand_m(); b2 = rand_m();
    start_op(a1, b1);
    repeat (5) tick();
    a_in = a2; b_in = b2; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0; first_edge = 0; z_first = '0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done_v[K8]) begin
        ndone++;
        if (first_edge == 0) begin
          first_edge = i + 6;
          z_first = z_v[K8];
        end
      end
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL busy_start_pulses got=%0d required=1", ndone);
    end
    checks++;
    if (z_first !== gf_mul(a1, b1) || first_edge != 22) begin
      errors++;
      $display("FAIL busy_start_result z=%h edge=%0d required z=%h edge=22", z_first, first_edge, gf_mul(a1, b1));
    end
    wait_all_idle();
  endtask

  task automatic test_clr();
    logic [M-1:0] z_prev, a2, b2;
    int nd, lat;
    z_prev = z_v[K8];
    start_op(rand_m(), rand_m());
    repeat (10) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (busy_v !== '0 || done_v !== '0) begin
      errors++;
      $display("FAIL clr_abort busy=%b done=%b required=0", busy_v, done_v);
    end
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done_v !== '0) nd++;
    end
    checks++;
    if (nd != 0 || z_v[K8] !== z_prev) begin
      errors++;
      $display("FAIL clr_quiet dones=%0d z=%h required dones=0 z=%h", nd, z_v[K8], z_prev);
    end
    a2 = rand_m(); b2 = rand_m();
    start_op(a2, b2);
    wait_done(K8, 40, lat);
    checks++;
    if (lat != 22 || z_v[K8] !== gf_mul(a2, b2)) begin
      errors++;
      $display("FAIL clr_restart lat=%0d z=%h required lat=22 z=%h", lat, z_v[K8], gf_mul(a2, b2));
    end
    wait_all_idle();
  endtask

  task automatic test_rst_mid_run();
    logic [M-1:0] a2, b2;
    int lat;
    start_op(rand_m(), rand_m());
    repeat (7) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy_v !== '0 || done_v !== '0) begin
      errors++;
      $display("FAIL rst_async_flags busy=%b done=%b required=0", busy_v, done_v);
    end
    for (int k = 0; k < NK; k++) begin
      checks++;
      if (z_v[k] !== '0) begin
        errors++;
        $display("FAIL rst_async_z D=%0d z=%h required=0", DV[k], z_v[k]);
      end
    end
    #1 rst = 1'b0;
    a2 = rand_m(); b2 = rand_m();
    start_op(a2, b2);
    wait_done(K8, 40, lat);
    checks++;
    if (lat != 22 || z_v[K8] !== gf_mul(a2, b2)) begin
      errors++;
      $display("FAIL rst_restart lat=%0d z=%h required lat=22 z=%h", lat, z_v[K8], gf_mul(a2, b2));
    end
    wait_all_idle();
  endtask

  task automatic test_back_to_back();
    logic [M-1:0] a1, b1, a2, b2;
    int lat;
    a1 = rand_m(); b1 = rand_m();
    a2 = rand_m(); b2 = rand_m();
    start_op(a1, b1);
    wait_done(K8, 40, lat);
    checks++;
    if (lat != 22 || z_v[K8] !== gf_mul(a1, b1)) begin
      errors++;
      $display("FAIL b2b_first lat=%0d z=%h required lat=22 z=%h", lat, z_v[K8], gf_mul(a1, b1));
    end
    start_op(a2, b2);
    checks++;
    if (busy_v[K8] !== 1'b1 || done_v[K8] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept busy=%b done=%b required busy=1 done=0", busy_v[K8], done_v[K8]);
    end
    wait_done(K8, 40, lat);
    checks++;
    if (lat != 22 || z_v[K8] !== gf_mul(a2, b2)) begin
      errors++;
      $display("FAIL b2b_second lat=%0d z=%h required lat=22 z=%h", lat, z_v[K8], gf_mul(a2, b2));
    end
    wait_all_idle();
  endtask

  task automatic test_sweep(input int nv);
    logic [M-1:0] x, y, exp_z;
    int lat [NK];
    for (int v = 0; v < nv; v++) begin
      x = rand_m();
      y = rand_m();
      if (v % 10 == 0) x = '0;
      if (v % 10 == 1) y = '0;
      if (v % 10 == 2) x = '1;
      exp_z = gf_mul(x, y);
      for (int k = 0; k < NK; k++) lat[k] = 0;
      start_op(x, y);
      for (int i = 1; i <= 200; i++) begin
        tick();
        for (int k = 0; k < NK; k++) begin
          if (done_v[k] && lat[k] == 0) begin
            lat[k] = i;
            checks++;
            if (z_v[k] !== exp_z) begin
              errors++;
              $display("FAIL sweep_z D=%0d vec=%0d z=%h required=%h", DV[k], v, z_v[k], exp_z);
            end
          end
        end
        if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && lat[3] != 0 && lat[4] != 0) break;
      end
      for (int k = 0; k < NK; k++) begin
        checks++;
        if (lat[k] != lat_of(k)) begin
          errors++;
          $display("FAIL sweep_latency D=%0d vec=%0d got=%0d required=%0d", DV[k], v, lat[k], lat_of(k));
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_one_by_one();
    test_wraparound();
    test_start_while_busy();
    test_clr();
    test_rst_mid_run();
    test_back_to_back();
    test_sweep(120);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
